// File: rtl/ddr_line_fetch_if.sv
// Command, pixel-stream and burst-read signals around the DDR line prefetcher.
// master = surrounding system (video path + burst-read block), slave = the prefetcher.
interface ddr_line_fetch_if;
  logic         line_start;
  logic [26:0]  line_addr;
  logic [10:0]  line_pixels;
  logic         line_busy;
  logic [23:0]  pix_data;
  logic         pix_valid;
  logic         pix_rd;
  logic [26:0]  mem_addr;
  logic         mem_rd;
  logic         mem_rd_ch;
  logic [7:0]   mem_burst;
  logic         mem_dout_ch;
  logic         mem_busy;
  logic         mem_dready;
  logic [959:0] mem960_dout;

  modport master (
    output line_start, line_addr, line_pixels, pix_rd, mem_busy, mem_dready, mem960_dout,
    input  line_busy, pix_data, pix_valid, mem_addr, mem_rd, mem_rd_ch, mem_burst, mem_dout_ch
  );

  modport slave (
    input  line_start, line_addr, line_pixels, pix_rd, mem_busy, mem_dready, mem960_dout,
    output line_busy, pix_data, pix_valid, mem_addr, mem_rd, mem_rd_ch, mem_burst, mem_dout_ch
  );
endinterface

// File: rtl/ddr_line_fetch.sv
// Line prefetcher: splits a pixel-line fetch into ping-pong DDR bursts of up to 40 pixels
// and unpacks the returned 960-bit chunks into a one-pixel-per-pop stream.
//
// state | meaning
// IDLE  | waiting for pixels left to fetch and an empty fill channel
// REQ   | one-cycle burst request pulse on mem_rd
// WAIT  | burst outstanding; request fields held until mem_dready
module ddr_line_fetch (
  input logic             DDRAM_CLK,
  input logic             reset_n,
  ddr_line_fetch_if.slave bus
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT} fill_state_t;

  fill_state_t state;
  logic [26:0] addr_q;
  logic [10:0] remain;
  logic [1:0]  full;
  logic        fill_ch;
  logic        drain_ch;
  logic [5:0]  pix_idx;
  logic [5:0]  cnt [2];
  logic        line_busy;
  logic        mem_rd;
  logic        mem_rd_ch;
  logic [7:0]  mem_burst;
  logic [26:0] mem_addr;

  logic [5:0]  chunk_n;
  logic [6:0]  burst_words;
  logic        start_ok;
  logic        pop;
  logic        last_in_chunk;
  logic        last_in_line;
  logic [9:0]  pix_base;
  logic        mem_busy_unused;

  always_comb begin
    chunk_n     = (remain > 11'd40) ? 6'd40 : remain[5:0];
    burst_words = ({1'b0, chunk_n} * 7'd3 + 7'd7) >> 3;
  end

  assign start_ok        = bus.line_start && !line_busy && (bus.line_pixels != 11'd0);
  assign pop             = bus.pix_rd && full[drain_ch];
  assign last_in_chunk   = (pix_idx == cnt[drain_ch] - 6'd1);
  assign last_in_line    = (remain == 11'd0) && !full[~drain_ch];
  assign pix_base        = {pix_idx, 4'b0000} + {1'b0, pix_idx, 3'b000};
  assign mem_busy_unused = bus.mem_busy;

  assign bus.line_busy   = line_busy;
  assign bus.pix_valid   = full[drain_ch];
  assign bus.pix_data    = bus.mem960_dout[pix_base +: 24];
  assign bus.mem_addr    = mem_addr;
  assign bus.mem_rd      = mem_rd;
  assign bus.mem_rd_ch   = mem_rd_ch;
  assign bus.mem_burst   = mem_burst;
  assign bus.mem_dout_ch = drain_ch;

  always_ff @(posedge DDRAM_CLK or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      addr_q    <= '0;
      remain    <= '0;
      full      <= 2'b00;
      fill_ch   <= 1'b0;
      drain_ch  <= 1'b0;
      pix_idx   <= '0;
      cnt[0]    <= '0;
      cnt[1]    <= '0;
      line_busy <= 1'b0;
      mem_rd    <= 1'b0;
      mem_rd_ch <= 1'b0;
      mem_burst <= '0;
      mem_addr  <= '0;
    end else if (start_ok) begin
      addr_q    <= bus.line_addr;
      remain    <= bus.line_pixels;
      full      <= 2'b00;
      fill_ch   <= 1'b0;
      drain_ch  <= 1'b0;
      pix_idx   <= '0;
      line_busy <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (line_busy && (remain != 11'd0) && !full[fill_ch]) begin
            state        <= REQ;
            mem_rd       <= 1'b1;
            mem_rd_ch    <= fill_ch;
            mem_addr     <= addr_q;
            mem_burst    <= {1'b0, burst_words};
            cnt[fill_ch] <= chunk_n;
          end
        end
        REQ: begin
          mem_rd <= 1'b0;
          state  <= WAIT;
        end
        WAIT: begin
          // request fields stay put: the burst block may sample them late
          if (bus.mem_dready) begin
            full[fill_ch] <= 1'b1;
            fill_ch       <= ~fill_ch;
            addr_q        <= addr_q + 27'd60;
            remain        <= remain - {5'd0, cnt[fill_ch]};
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      // fill never targets the draining channel, so both full[] writes are disjoint
      if (pop) begin
        if (last_in_chunk) begin
          full[drain_ch] <= 1'b0;
          drain_ch       <= ~drain_ch;
          pix_idx        <= '0;
          if (last_in_line) line_busy <= 1'b0;
        end else begin
          pix_idx <= pix_idx + 6'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_ddr_line_fetch.sv
// Scoreboard bench for ddr_line_fetch: expected bursts and pixels are queued at stimulus
// time and popped by monitors; a burst-read model fills the two 960-bit channels.
module tb_ddr_line_fetch;
  localparam int LAT = 6;

  logic DDRAM_CLK = 1'b0;
  logic reset_n   = 1'b0;
  always #5 DDRAM_CLK = ~DDRAM_CLK;

  ddr_line_fetch_if bus();

  ddr_line_fetch dut (
    .DDRAM_CLK (DDRAM_CLK),
    .reset_n   (reset_n),
    .bus       (bus)
  );

  typedef struct packed {
    logic [26:0] addr;
    logic [7:0]  burst;
    logic        ch;
  } req_t;

  typedef struct packed {
    logic        ch;
    logic [23:0] data;
  } pix_t;

  req_t         exp_req [$];
  pix_t         exp_pix [$];
  logic [959:0] ch_mem [2];
  int           pass_cnt = 0;
  int           total_cnt = 0;
  int           req_cnt = 0;
  int           pop_cnt = 0;
  int           cyc = 0;
  bit           busy_fall_pending = 0;
  logic         mem_rd_prev = 1'b0;
  req_t         mon_er;
  pix_t         mon_ep;

  assign bus.mem960_dout = ch_mem[bus.mem_dout_ch];

  always @(posedge DDRAM_CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic fail_now(input string name, input string why);
    total_cnt++;
    $display("FAIL %s: %s", name, why);
  endtask

  function automatic logic [63:0] word_of(input logic [26:0] wa);
    return {5'h00, wa, 5'h1f, ~wa};
  endfunction

  function automatic logic [959:0] chunk_of(input logic [26:0] a);
    logic [959:0] c;
    for (int w = 0; w < 15; w++) c[64*w +: 64] = word_of(a + 27'(4*w));
    return c;
  endfunction

  task automatic push_req(input logic [26:0] a, input logic [7:0] b, input logic c);
    req_t r;
    r.addr  = a;
    r.burst = b;
    r.ch    = c;
    exp_req.push_back(r);
  endtask

  task automatic push_line(input logic [26:0] a, input int n);
    for (int i = 0; i < n; i++) begin
      logic [959:0] c;
      pix_t p;
      c      = chunk_of(a + 27'(60*(i/40)));
      p.ch   = ((i/40) % 2) == 1;
      p.data = c[24*(i%40) +: 24];
      exp_pix.push_back(p);
    end
  endtask

  task automatic start_line(input logic [26:0] a, input logic [10:0] n);
    bus.line_addr   = a;
    bus.line_pixels = n;
    bus.line_start  = 1'b1;
    @(posedge DDRAM_CLK); #1;
    bus.line_start  = 1'b0;
  endtask

  task automatic wait_valid(input string name, input int max_cyc);
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge DDRAM_CLK);
      if (bus.pix_valid) return;
    end
    fail_now(name, "timed out waiting for pix_valid");
  endtask

  task automatic wait_idle(input string name, input int max_cyc);
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge DDRAM_CLK);
      if (!bus.line_busy) return;
    end
    fail_now(name, "timed out waiting for line_busy low");
  endtask

  task automatic pop_n(input string name, input int n);
    int target;
    target = pop_cnt + n;
    bus.pix_rd = 1'b1;
    for (int i = 0; i < 10*n + 50; i++) begin
      @(posedge DDRAM_CLK); #1;
      if (pop_cnt >= target) begin
        bus.pix_rd = 1'b0;
        return;
      end
    end
    bus.pix_rd = 1'b0;
    fail_now(name, "timed out popping pixels");
  endtask

  // burst-read model: samples request fields when it completes, as the real block may
  initial forever begin
    @(negedge DDRAM_CLK);
    if (bus.mem_rd) begin
      bus.mem_busy = 1'b1;
      repeat (LAT) @(posedge DDRAM_CLK);
      #1;
      for (int w = 0; w < int'(bus.mem_burst) && w < 15; w++)
        ch_mem[bus.mem_rd_ch][64*w +: 64] = word_of(bus.mem_addr + 27'(4*w));
      bus.mem_busy   = 1'b0;
      bus.mem_dready = 1'b1;
      @(posedge DDRAM_CLK); #1;
      bus.mem_dready = 1'b0;
    end
  end

  initial forever begin
    @(negedge DDRAM_CLK);
    if (busy_fall_pending) begin
      check("busy_fall_after_last_pop", 64'(bus.line_busy), 64'(0));
      busy_fall_pending = 0;
    end
    if (mem_rd_prev) check("mem_rd_pulse_width", 64'(bus.mem_rd), 64'(0));
    mem_rd_prev = bus.mem_rd;
    if (bus.mem_rd) begin
      req_cnt++;
      if (exp_req.size() == 0) begin
        fail_now("req", $sformatf("unexpected request addr %0h burst %0d ch %0d",
                 bus.mem_addr, bus.mem_burst, bus.mem_rd_ch));
      end else begin
        mon_er = exp_req.pop_front();
        check("req_addr_burst_ch", 64'({bus.mem_addr, bus.mem_burst, bus.mem_rd_ch}), 64'(mon_er));
      end
    end
    if (bus.pix_valid && bus.pix_rd) begin
      pop_cnt++;
      if (exp_pix.size() == 0) begin
        fail_now("pixel", $sformatf("unexpected pop data %0h", bus.pix_data));
      end else begin
        mon_ep = exp_pix.pop_front();
        check("pixel_ch_data", 64'({bus.mem_dout_ch, bus.pix_data}), 64'(mon_ep));
        if (exp_pix.size() == 0) begin
          check("busy_at_last_pop", 64'(bus.line_busy), 64'(1));
          busy_fall_pending = 1;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int r0;
    bit seen;
    bus.line_start  = 1'b0;
    bus.line_addr   = '0;
    bus.line_pixels = '0;
    bus.pix_rd      = 1'b0;
    bus.mem_busy    = 1'b0;
    bus.mem_dready  = 1'b0;
    ch_mem[0]       = '0;
    ch_mem[1]       = '0;

    repeat (3) @(posedge DDRAM_CLK);
    #1;
    check("rst_mem_rd",      64'(bus.mem_rd),      64'(0));
    check("rst_mem_rd_ch",   64'(bus.mem_rd_ch),   64'(0));
    check("rst_mem_burst",   64'(bus.mem_burst),   64'(0));
    check("rst_mem_addr",    64'(bus.mem_addr),    64'(0));
    check("rst_mem_dout_ch", 64'(bus.mem_dout_ch), 64'(0));
    check("rst_line_busy",   64'(bus.line_busy),   64'(0));
    check("rst_pix_valid",   64'(bus.pix_valid),   64'(0));
    reset_n = 1'b1;
    @(posedge DDRAM_CLK); #1;

    // 40 pixels: single full burst, back-to-back drain
    push_req(27'h100, 8'd15, 1'b0);
    push_line(27'h100, 40);
    bus.pix_rd = 1'b1;
    start_line(27'h100, 11'd40);
    check("t1_busy_cycle1", 64'(bus.line_busy), 64'(1));
    check("t1_rd_cycle1",   64'(bus.mem_rd),    64'(0));
    @(posedge DDRAM_CLK); #1;
    check("t1_rd_cycle2",   64'(bus.mem_rd),    64'(1));
    wait_valid("t1_valid", 50);
    c0 = cyc;
    wait_idle("t1_idle", 200);
    check("t1_drain_cycles", 64'(cyc - c0), 64'(40));

    // 100 pixels: bursts 15/15/8 on ch 0/1/0
    r0 = req_cnt;
    push_req(27'h200, 8'd15, 1'b0);
    push_req(27'h23C, 8'd15, 1'b1);
    push_req(27'h278, 8'd8,  1'b0);
    push_line(27'h200, 100);
    start_line(27'h200, 11'd100);
    wait_idle("t2_idle", 1000);
    check("t2_req_count", 64'(req_cnt - r0), 64'(3));

    // backpressure: two chunks buffered, third request only after ch0 drains
    bus.pix_rd = 1'b0;
    r0 = req_cnt;
    push_req(27'h400, 8'd15, 1'b0);
    push_req(27'h43C, 8'd15, 1'b1);
    push_req(27'h478, 8'd15, 1'b0);
    push_req(27'h4B4, 8'd15, 1'b1);
    push_req(27'h4F0, 8'd15, 1'b0);
    push_line(27'h400, 200);
    start_line(27'h400, 11'd200);
    repeat (40) @(posedge DDRAM_CLK);
    #1;
    check("t3_stall_two_reqs", 64'(req_cnt - r0), 64'(2));
    check("t3_valid_stalled",  64'(bus.pix_valid), 64'(1));
    pop_n("t3_pop40", 40);
    repeat (5) @(posedge DDRAM_CLK);
    #1;
    check("t3_third_req", 64'(req_cnt - r0), 64'(3));
    bus.pix_rd = 1'b1;
    wait_idle("t3_idle", 2000);
    check("t3_req_count", 64'(req_cnt - r0), 64'(5));

    // single pixel line
    push_req(27'h040, 8'd1, 1'b0);
    push_line(27'h040, 1);
    start_line(27'h040, 11'd1);
    wait_idle("t4_idle", 100);

    // ignored commands: during a busy line, and with zero pixels
    bus.pix_rd = 1'b0;
    r0 = req_cnt;
    push_req(27'h800, 8'd15, 1'b0);
    push_req(27'h83C, 8'd4,  1'b1);
    push_line(27'h800, 50);
    start_line(27'h800, 11'd50);
    repeat (3) @(posedge DDRAM_CLK);
    #1;
    start_line(27'h1000, 11'd5);
    repeat (30) @(posedge DDRAM_CLK);
    #1;
    check("t5_reqs_while_busy", 64'(req_cnt - r0), 64'(2));
    bus.pix_rd = 1'b1;
    wait_idle("t5_idle", 500);
    start_line(27'h1400, 11'd0);
    repeat (20) @(posedge DDRAM_CLK);
    #1;
    check("t5_zero_len_busy", 64'(bus.line_busy), 64'(0));
    check("t5_zero_len_reqs", 64'(req_cnt - r0), 64'(2));

    // reset while a burst is outstanding
    bus.pix_rd = 1'b0;
    push_req(27'hA00, 8'd15, 1'b0);
    start_line(27'hA00, 11'd80);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge DDRAM_CLK);
      if (bus.mem_rd) seen = 1;
    end
    if (!seen) fail_now("t6_req", "timed out waiting for mem_rd");
    repeat (2) @(posedge DDRAM_CLK);
    #1;
    reset_n = 1'b0;
    #1;
    check("t6_async_busy",     64'(bus.line_busy),   64'(0));
    check("t6_async_mem_addr", 64'(bus.mem_addr),    64'(0));
    check("t6_async_burst",    64'(bus.mem_burst),   64'(0));
    check("t6_async_rd",       64'(bus.mem_rd),      64'(0));
    check("t6_async_dout_ch",  64'(bus.mem_dout_ch), 64'(0));
    exp_req.delete();
    exp_pix.delete();
    @(posedge DDRAM_CLK); #1;
    reset_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge DDRAM_CLK);
      if (bus.pix_valid) seen = 1;
    end
    check("t6_late_dready_ignored", 64'(seen), 64'(0));
    check("t6_idle_after_reset",    64'(bus.line_busy), 64'(0));
    @(posedge DDRAM_CLK); #1;
    bus.pix_rd = 1'b1;
    push_req(27'hC00, 8'd15, 1'b0);
    push_line(27'hC00, 40);
    start_line(27'hC00, 11'd40);
    wait_idle("t6_idle", 200);

    repeat (10) @(posedge DDRAM_CLK);
    #1;
    check("exp_req_drained", 64'(exp_req.size()), 64'(0));
    check("exp_pix_drained", 64'(exp_pix.size()), 64'(0));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
